alu_adder4_data_memory: RTL and testbench
=========================================

ALU_ADDER4_DATA_MEMORY -- requirements
Module: alu_adder4_data_memory

Interface
REQ-001 Parameter MEM_DEPTH, default 512, memory size in bytes.
REQ-002 Parameter ADDR_W, default 9, byte-address width (log2 MEM_DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 alu_a  in  32  ALU operand A (shift amount source for shift ops).
REQ-006 alu_b  in  32  ALU operand B.
REQ-007 alu_opcode  in  4  ALU operation select.
REQ-008 alu_out  out  32  ALU result.
REQ-009 alu_z  out  1  zero flag.
REQ-010 alu_n  out  1  negative flag.
REQ-011 adder_in  in  32  PC value.
REQ-012 adder_out  out  32  adder_in + 4.
REQ-013 mem_a  in  ADDR_W  byte address.
REQ-014 mem_di  in  32  write data.
REQ-015 mem_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-016 mem_rw  in  1  0 read, 1 write.
REQ-017 mem_e  in  1  memory enable.
REQ-018 mem_se  in  1  1 sign-extend byte/halfword reads, 0 zero-extend.
REQ-019 mem_do  out  32  read data.

Function
REQ-020 ALU, adder and memory read path are purely combinational; no latency.
REQ-021 Opcodes: 0000 A+B; 0001 A-B; 0010 A&B; 0011 A|B; 0100 A^B; 0101 ~(A|B); 0110 B<<A[4:0]; 0111 B>>A[4:0] logical; 1000 B>>>A[4:0] arithmetic; 1001 signed A<B ? 1:0; 1010 unsigned A<B ? 1:0; 1011 pass A; 1100 pass B; 1101 B+8; 1110, 1111 result 0.
REQ-022 Add/sub wrap modulo 2^32; no overflow/carry output.
REQ-023 alu_z = (alu_out == 0); alu_n = alu_out[31]; both derived from final result for every opcode.
REQ-024 adder_out = adder_in + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-025 Memory is byte array, big-endian: byte at mem_a is most significant.
REQ-026 Multi-byte access uses bytes mem_a, mem_a+1, ..., wrapping modulo MEM_DEPTH; no alignment enforcement.
REQ-027 Write: on rising clk when reset=1, mem_e=1, mem_rw=1: byte writes mem_di[7:0]; halfword writes mem_di[15:0]; word writes mem_di[31:0].
REQ-028 Read: when mem_e=1 and mem_rw=0, mem_do returns byte/halfword/word per mem_size, extended to 32 bits per mem_se; word ignores mem_se.
REQ-029 mem_do = 0 whenever mem_e=0 or mem_rw=1.
REQ-030 Read of location written in same cycle returns old contents until the edge, new contents after.

Reset
REQ-031 While reset=0 at a rising edge, all MEM_DEPTH bytes clear to 0 and any requested write is suppressed.
REQ-032 Combinational outputs (alu_*, adder_out, mem_do) are unaffected by reset apart from memory contents.

Structure
REQ-033 Shared package holds ALU opcode constants, mem_size codes, MEM_DEPTH/ADDR_W defaults.
REQ-034 One sub-module, data_memory, holds the byte array and read/write logic; ALU and adder stay inline.

Verification
REQ-035 ALU: A=5, B=3, op 0001 -> out 2, z 0, n 0; A=3, B=5, op 0001 -> 0xFFFFFFFE, n 1; A=B=7, op 0001 -> z 1.
REQ-036 Shifts/compare: A=4, B=0x80000000, op 1000 -> 0xF8000000; op 0111 -> 0x08000000; A=0xFFFFFFFF, B=1, op 1001 -> 1, op 1010 -> 0.
REQ-037 Adder: 0 -> 4; 0xFFFFFFFC -> 0; op 1101 with B=0x10 -> 0x18.
REQ-038 Memory word/bytes: write word 0xA1B2C3D4 at 8; read byte at 8 SE=1 -> 0xFFFFFFA1, SE=0 -> 0x000000A1; halfword at 10 SE=1 -> 0xFFFFC3D4; word at 8 -> 0xA1B2C3D4.
REQ-039 Wrap/enable: word write 0x11223344 at 510 -> byte 0 reads 0x33, byte 1 reads 0x44; write with mem_e=0 leaves contents unchanged; mem_do=0 while mem_e=0.
REQ-040 Reset: after writes, one edge with reset=0 -> every read returns 0; write asserted during reset is not stored.

Source files
------------

// File: rtl/alu_adder4_data_memory_pkg.sv
// Shared definitions for the ALU / PC adder / data memory slice: opcodes,
// access-size codes and default memory geometry.
package alu_adder4_data_memory_pkg;

  localparam int MEM_DEPTH_DEF = 512;
  localparam int ADDR_W_DEF    = 9;
  localparam int NUM_LANES     = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_PASSA = 4'b1011,
    OP_PASSB = 4'b1100,
    OP_ADD8  = 4'b1101,
    OP_ZERO0 = 4'b1110,
    OP_ZERO1 = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD2 = 2'b11
  } mem_size_e;

  // Number of bytes touched by an access; code 11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (mem_size_e'(size))
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/alu_adder4_data_memory_data_memory.sv
// Big-endian byte-addressed data memory: combinational read, synchronous
// write, byte lanes wrap modulo MEM_DEPTH, synchronous clear on reset.
module data_memory
  import alu_adder4_data_memory_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [31:0]       mem_di,
  input  logic [1:0]        mem_size,
  input  logic              mem_rw,
  input  logic              mem_e,
  input  logic              mem_se,
  output logic [31:0]       mem_do
);

  localparam int AW1 = ADDR_W + 1;

  logic [7:0] mem_q [MEM_DEPTH];

  logic [2:0]                              nbytes;
  logic [31:0]                             wdata_al;
  logic [NUM_LANES-1:0][ADDR_W-1:0]        lane_addr;
  logic [NUM_LANES-1:0][7:0]               lane_wdata;
  logic [NUM_LANES-1:0][7:0]               lane_rdata;
  logic [NUM_LANES-1:0]                    lane_we;

  assign nbytes = size_bytes(mem_size);
  // Left-justify the active bytes so lane 0 always carries the MSB.
  assign wdata_al = mem_di << {3'd4 - nbytes, 3'b000};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [AW1-1:0] sum;
    assign sum           = {1'b0, mem_a} + AW1'(k);
    assign lane_addr[k]  = (sum >= AW1'(MEM_DEPTH)) ? ADDR_W'(sum - AW1'(MEM_DEPTH))
                                                     : sum[ADDR_W-1:0];
    assign lane_we[k]    = mem_e & mem_rw & (3'(k) < nbytes);
    assign lane_wdata[k] = wdata_al[31-8*k -: 8];
    assign lane_rdata[k] = mem_q[lane_addr[k]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (lane_we[k]) mem_q[lane_addr[k]] <= lane_wdata[k];
    end
  end

  always_comb begin
    mem_do = '0;
    if (mem_e && !mem_rw) begin
      case (mem_size_e'(mem_size))
        SZ_BYTE: mem_do = {{24{mem_se & lane_rdata[0][7]}}, lane_rdata[0]};
        SZ_HALF: mem_do = {{16{mem_se & lane_rdata[0][7]}}, lane_rdata[0], lane_rdata[1]};
        default: mem_do = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
      endcase
    end
  end

endmodule

// File: rtl/alu_adder4_data_memory.sv
// Datapath slice: combinational 32-bit ALU with flags, PC+4 adder, and the
// byte-addressed data memory.
module alu_adder4_data_memory
  import alu_adder4_data_memory_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       alu_a,
  input  logic [31:0]       alu_b,
  input  logic [3:0]        alu_opcode,
  output logic [31:0]       alu_out,
  output logic              alu_z,
  output logic              alu_n,
  input  logic [31:0]       adder_in,
  output logic [31:0]       adder_out,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [31:0]       mem_di,
  input  logic [1:0]        mem_size,
  input  logic              mem_rw,
  input  logic              mem_e,
  input  logic              mem_se,
  output logic [31:0]       mem_do
);

  logic [4:0] shamt;
  assign shamt = alu_a[4:0];

  always_comb begin
    alu_out = '0;
    case (alu_op_e'(alu_opcode))
      OP_ADD:   alu_out = alu_a + alu_b;
      OP_SUB:   alu_out = alu_a - alu_b;
      OP_AND:   alu_out = alu_a & alu_b;
      OP_OR:    alu_out = alu_a | alu_b;
      OP_XOR:   alu_out = alu_a ^ alu_b;
      OP_NOR:   alu_out = ~(alu_a | alu_b);
      OP_SLL:   alu_out = alu_b << shamt;
      OP_SRL:   alu_out = alu_b >> shamt;
      OP_SRA:   alu_out = $unsigned($signed(alu_b) >>> shamt);
      OP_SLT:   alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU:  alu_out = {31'b0, alu_a < alu_b};
      OP_PASSA: alu_out = alu_a;
      OP_PASSB: alu_out = alu_b;
      OP_ADD8:  alu_out = alu_b + 32'd8;
      default:  alu_out = '0;
    endcase
  end

  assign alu_z     = (alu_out == 32'd0);
  assign alu_n     = alu_out[31];
  assign adder_out = adder_in + 32'd4;

  data_memory #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk      (clk),
    .reset    (reset),
    .mem_a    (mem_a),
    .mem_di   (mem_di),
    .mem_size (mem_size),
    .mem_rw   (mem_rw),
    .mem_e    (mem_e),
    .mem_se   (mem_se),
    .mem_do   (mem_do)
  );

endmodule

// File: tb/tb_alu_adder4_data_memory.sv
// Bench for alu_adder4_data_memory: directed literal checks followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_adder4_data_memory;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_out, adder_in, adder_out, mem_di, mem_do;
  logic [3:0]  alu_opcode;
  logic        alu_z, alu_n, mem_rw, mem_e, mem_se;
  logic [8:0]  mem_a;
  logic [1:0]  mem_size;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_mem [DEPTH];

  alu_adder4_data_memory #(.MEM_DEPTH(DEPTH), .ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .adder_in(adder_in),
    .adder_out(adder_out), .mem_a(mem_a), .mem_di(mem_di), .mem_size(mem_size),
    .mem_rw(mem_rw), .mem_e(mem_e), .mem_se(mem_se), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  function automatic int nb(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    int sh;
    sh = int'(a % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return b << sh;
      4'd7:  return b >> sh;
      4'd8:  return b[31] ? ~((~b) >> sh) : (b >> sh);
      4'd9:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return a;
      4'd12: return b;
      4'd13: return b + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int a, input logic [1:0] s, input logic se);
    logic [31:0] v;
    int n;
    n = nb(s);
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(m_mem[(a + i) % DEPTH]);
    if (n == 1 && se && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && se && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Reference memory state, updated on the same edge as the DUT.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    end else if (mem_e && mem_rw) begin
      for (int i = 0; i < nb(mem_size); i++)
        m_mem[(int'(mem_a) + i) % DEPTH] = 8'((mem_di >> (8 * (nb(mem_size) - 1 - i))));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] e_alu, e_do;
      e_alu = m_alu(alu_a, alu_b, alu_opcode);
      e_do  = (mem_e && !mem_rw) ? m_read(int'(mem_a), mem_size, mem_se) : 32'd0;
      chk("model_alu_out", alu_out, e_alu);
      chk("model_alu_z", 32'(alu_z), 32'(e_alu == 0));
      chk("model_alu_n", 32'(alu_n), 32'(e_alu[31]));
      chk("model_adder", adder_out, adder_in + 32'd4);
      chk("model_mem_do", mem_do, e_do);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic alu_set(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    tick();
    alu_a = a; alu_b = b; alu_opcode = op;
    look();
  endtask

  task automatic mem_set(input int a, input logic [31:0] di, input logic [1:0] s,
                         input logic rw, input logic e, input logic se);
    tick();
    mem_a = 9'(a); mem_di = di; mem_size = s; mem_rw = rw; mem_e = e; mem_se = se;
    look();
  endtask

  initial begin
    reset = 1'b0; alu_a = 0; alu_b = 0; alu_opcode = 0; adder_in = 0;
    mem_a = 0; mem_di = 0; mem_size = 0; mem_rw = 0; mem_e = 0; mem_se = 0;
    tick(); tick();
    reset = 1'b1;
    chk_en = 1'b1;

    mem_set(0, 0, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("reset_word0", mem_do, 32'h0);
    chk("adder_0", adder_out, 32'h4);

    alu_set(5, 3, 4'b0001);
    chk("sub_5_3", alu_out, 32'd2); chk("sub_5_3_z", 32'(alu_z), 0); chk("sub_5_3_n", 32'(alu_n), 0);
    alu_set(3, 5, 4'b0001);
    chk("sub_3_5", alu_out, 32'hFFFF_FFFE); chk("sub_3_5_n", 32'(alu_n), 1);
    alu_set(7, 7, 4'b0001);
    chk("sub_7_7_z", 32'(alu_z), 1);
    alu_set(4, 32'h8000_0000, 4'b1000);
    chk("sra", alu_out, 32'hF800_0000);
    alu_set(4, 32'h8000_0000, 4'b0111);
    chk("srl", alu_out, 32'h0800_0000);
    alu_set(32'hFFFF_FFFF, 1, 4'b1001);
    chk("slt", alu_out, 32'd1);
    alu_set(32'hFFFF_FFFF, 1, 4'b1010);
    chk("sltu", alu_out, 32'd0);
    alu_set(0, 32'h10, 4'b1101);
    chk("add8", alu_out, 32'h18);
    adder_in = 32'hFFFF_FFFC;
    alu_set(0, 0, 4'b1110);
    chk("adder_wrap", adder_out, 32'h0);
    chk("op_e_zero_z", 32'(alu_z), 1);

    mem_set(8, 32'hA1B2_C3D4, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("do_during_write", mem_do, 32'h0);
    mem_set(8, 0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("byte8_se", mem_do, 32'hFFFF_FFA1);
    mem_set(8, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("byte8_ze", mem_do, 32'h0000_00A1);
    mem_set(10, 0, 2'b01, 1'b0, 1'b1, 1'b1);
    chk("half10_se", mem_do, 32'hFFFF_C3D4);
    mem_set(8, 0, 2'b10, 1'b0, 1'b1, 1'b1);
    chk("word8", mem_do, 32'hA1B2_C3D4);

    mem_set(510, 32'h1122_3344, 2'b10, 1'b1, 1'b1, 1'b0);
    mem_set(0, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("wrap_byte0", mem_do, 32'h33);
    mem_set(1, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("wrap_byte1", mem_do, 32'h44);
    mem_set(510, 0, 2'b11, 1'b0, 1'b1, 1'b0);
    chk("wrap_word510", mem_do, 32'h1122_3344);

    mem_set(8, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("disabled_do", mem_do, 32'h0);
    mem_set(8, 0, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("disabled_read", mem_do, 32'h0);
    mem_set(8, 0, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("no_write_when_off", mem_do, 32'hA1B2_C3D4);

    tick();
    reset = 1'b0;
    mem_a = 9'd8; mem_di = 32'h5566_7788; mem_size = 2'b10; mem_rw = 1'b1; mem_e = 1'b1;
    tick();
    reset = 1'b1;
    mem_rw = 1'b0;
    look();
    chk("reset_clear_8", mem_do, 32'h0);
    mem_set(510, 0, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("reset_clear_510", mem_do, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      reset      = ($urandom_range(0, 199) != 0);
      alu_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      alu_b      = $urandom;
      alu_opcode = 4'($urandom);
      adder_in   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      case ($urandom_range(0, 2))
        0:       mem_a = 9'($urandom_range(0, 15));
        1:       mem_a = 9'($urandom_range(505, 511));
        default: mem_a = 9'($urandom);
      endcase
      mem_di   = $urandom;
      mem_size = 2'($urandom);
      mem_rw   = ($urandom_range(0, 2) == 0);
      mem_e    = ($urandom_range(0, 5) != 0);
      mem_se   = 1'($urandom);
    end
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
